// File: rtl/pip_reg_stage.sv
// Parametrised pipeline register (1..4 stages) with per-instruction valid, stall hold and per-stage flush.
// Optional performance counters are compiled in when PIP_REG_PERF_EN is defined.
module pip_reg_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4,
  parameter int STAGES     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic [STAGES-1:0]     flush_i,
  input  logic                  valid_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
`ifdef PIP_REG_PERF_EN
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           bubble_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o
);

  if (STAGES < 1 || STAGES > 4) begin : g_stages_chk
    $error("pip_reg_stage: STAGES must be within 1..4");
  end

  logic                  valid_q [STAGES];
  logic                  valid_d [STAGES];
  logic [CTRL_WIDTH-1:0] ctrl_q  [STAGES];
  logic [CTRL_WIDTH-1:0] ctrl_d  [STAGES];
  logic [DATA_WIDTH-1:0] data_q  [STAGES];
  logic [DATA_WIDTH-1:0] data_d  [STAGES];

  // Next-state per stage: flush beats stall, stall beats capture.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      data_d[k]  = data_q[k];
    end
    if (flush_i[0]) begin
      valid_d[0] = 1'b0;
      ctrl_d[0]  = {CTRL_WIDTH{1'b0}};
      data_d[0]  = {DATA_WIDTH{1'b0}};
    end else if (stall_i) begin
      valid_d[0] = valid_q[0];
      ctrl_d[0]  = ctrl_q[0];
      data_d[0]  = data_q[0];
    end else begin
      // Control is gated at capture so an invalid entry can never carry a write enable.
      valid_d[0] = valid_i;
      ctrl_d[0]  = valid_i ? ctrl_i : {CTRL_WIDTH{1'b0}};
      data_d[0]  = data_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (flush_i[k]) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = {CTRL_WIDTH{1'b0}};
        data_d[k]  = {DATA_WIDTH{1'b0}};
      end else if (stall_i) begin
        valid_d[k] = valid_q[k];
        ctrl_d[k]  = ctrl_q[k];
        data_d[k]  = data_q[k];
      end else begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= {CTRL_WIDTH{1'b0}};
        data_q[k]  <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign ctrl_o  = ctrl_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

`ifdef PIP_REG_PERF_EN
  function automatic logic [2:0] popcnt(input logic [STAGES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < STAGES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;
  logic [32:0] bubble_sum_s;

  // Saturating counter updates.
  always_comb begin
    bubble_sum_s = {1'b0, bubble_cnt_q} + {30'd0, popcnt(flush_i)};
    if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (bubble_sum_s[32]) begin
      bubble_cnt_d = 32'hFFFF_FFFF;
    end else begin
      bubble_cnt_d = bubble_sum_s[31:0];
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
